// File: rtl/glb_store_dma_packer_if.sv
// Stream-in / bank-write-out signal bundle for the GLB store DMA packer.
// slave is the packer's view; master is the CGRA/bank-side view.
interface glb_store_dma_packer_if #(
  parameter int unsigned CGRA_DATA_WIDTH = 16,
  parameter int unsigned BANK_DATA_WIDTH = 64,
  parameter int unsigned BANK_STRB_WIDTH = 8,
  parameter int unsigned GLB_ADDR_WIDTH  = 19
);
  logic [CGRA_DATA_WIDTH-1:0] strm_data_in;
  logic                       strm_valid_in;
  logic                       strm_ready_out;
  logic                       wr_en_out;
  logic [GLB_ADDR_WIDTH-1:0]  wr_addr_out;
  logic [BANK_DATA_WIDTH-1:0] wr_data_out;
  logic [BANK_STRB_WIDTH-1:0] wr_strb_out;
  logic                       wr_ready_in;

  modport slave (
    input  strm_data_in, strm_valid_in, wr_ready_in,
    output strm_ready_out, wr_en_out, wr_addr_out, wr_data_out, wr_strb_out
  );

  modport master (
    output strm_data_in, strm_valid_in, wr_ready_in,
    input  strm_ready_out, wr_en_out, wr_addr_out, wr_data_out, wr_strb_out
  );
endinterface

// File: rtl/glb_store_dma_packer.sv
// GLB store DMA: packs 16-bit stream words into strobed 64-bit bank writes via a small FIFO.
// Optional GLB_ST_DMA_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module glb_store_dma_packer #(
  parameter int unsigned CGRA_DATA_WIDTH      = 16,
  parameter int unsigned BANK_DATA_WIDTH      = 64,
  parameter int unsigned BANK_STRB_WIDTH      = 8,
  parameter int unsigned GLB_ADDR_WIDTH       = 19,
  parameter int unsigned STORE_DMA_FIFO_DEPTH = 4,
  parameter int unsigned MAX_NUM_WORDS_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start,
  input  logic [1:0]                     cfg_mode,
  input  logic [GLB_ADDR_WIDTH-1:0]      cfg_start_addr,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0] cfg_num_words,
  glb_store_dma_packer_if.slave          bus,
  output logic                           busy_out,
  output logic                           done_pulse_out,
  output logic                           overflow_out
`ifdef GLB_ST_DMA_CYCLE_COUNT_EN
  ,
  output logic [15:0]                    cycle_count_out
`endif
);

  localparam int unsigned Lanes     = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int unsigned LaneW     = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int unsigned LaneBytes = CGRA_DATA_WIDTH / 8;
  localparam int unsigned PtrW      = $clog2(STORE_DMA_FIFO_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam logic [1:0]  ModeValid  = 2'd0;
  localparam logic [1:0]  ModeStatic = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     mode_q, mode_d;
  logic [GLB_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [MAX_NUM_WORDS_WIDTH-1:0] rem_q, rem_d;
  logic [LaneW-1:0]               lane_q, lane_d;
  logic [BANK_DATA_WIDTH-1:0]     pack_data_q, pack_data_d, pack_data_acc;
  logic [BANK_STRB_WIDTH-1:0]     pack_strb_q, pack_strb_d, pack_strb_acc;
  logic                           overflow_q, overflow_d;

  logic [GLB_ADDR_WIDTH-1:0]  fifo_addr_q [STORE_DMA_FIFO_DEPTH];
  logic [BANK_DATA_WIDTH-1:0] fifo_data_q [STORE_DMA_FIFO_DEPTH];
  logic [BANK_STRB_WIDTH-1:0] fifo_strb_q [STORE_DMA_FIFO_DEPTH];
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            count_q;

  logic fifo_full, fifo_empty, start_acc, strm_ready, accept;
  logic last_word, need_push, push, drop, pop;

  assign fifo_full  = (count_q == CntW'(STORE_DMA_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign start_acc  = cfg_start && (state_q == StIdle);
  assign last_word  = (rem_q == MAX_NUM_WORDS_WIDTH'(1));
  assign need_push  = accept && ((lane_q == LaneW'(Lanes - 1)) || last_word);
  // VALID mode cannot stall the source, so a full FIFO loses the packed entry.
  assign push       = need_push && !fifo_full;
  assign drop       = need_push && fifo_full;
  assign pop        = !fifo_empty && bus.wr_ready_in;

  always_comb begin
    strm_ready = 1'b0;
    accept     = 1'b0;
    if (state_q == StRun && rem_q != '0) begin
      if (mode_q == ModeValid) begin
        strm_ready = 1'b1;
        accept     = bus.strm_valid_in;
      end else if (mode_q == ModeStatic) begin
        strm_ready = !fifo_full;
        accept     = !fifo_full;
      end else begin
        strm_ready = !fifo_full;
        accept     = bus.strm_valid_in && !fifo_full;
      end
    end
  end

  always_comb begin
    pack_data_acc = pack_data_q;
    pack_strb_acc = pack_strb_q;
    for (int unsigned l = 0; l < Lanes; l++) begin
      if (lane_q == LaneW'(l)) begin
        pack_data_acc[l*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = bus.strm_data_in;
        pack_strb_acc[l*LaneBytes +: LaneBytes]             = '1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = StRun;
      StRun:   if (rem_q == '0 || (accept && last_word)) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    lane_d      = lane_q;
    pack_data_d = pack_data_q;
    pack_strb_d = pack_strb_q;
    overflow_d  = overflow_q;
    if (start_acc) begin
      mode_d      = cfg_mode;
      addr_d      = cfg_start_addr & ~GLB_ADDR_WIDTH'(BANK_STRB_WIDTH - 1);
      rem_d       = cfg_num_words;
      lane_d      = '0;
      pack_data_d = '0;
      pack_strb_d = '0;
      overflow_d  = 1'b0;
    end else if (accept) begin
      rem_d = rem_q - MAX_NUM_WORDS_WIDTH'(1);
      if (need_push) begin
        // Address advances even on a dropped entry so later writes keep their slots.
        addr_d      = addr_q + GLB_ADDR_WIDTH'(BANK_STRB_WIDTH);
        lane_d      = '0;
        pack_data_d = '0;
        pack_strb_d = '0;
        if (drop) overflow_d = 1'b1;
      end else begin
        lane_d      = lane_q + LaneW'(1);
        pack_data_d = pack_data_acc;
        pack_strb_d = pack_strb_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      lane_q      <= '0;
      pack_data_q <= '0;
      pack_strb_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      lane_q      <= lane_d;
      pack_data_q <= pack_data_d;
      pack_strb_q <= pack_strb_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STORE_DMA_FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_strb_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= addr_q;
        fifo_data_q[wr_ptr_q] <= pack_data_acc;
        fifo_strb_q[wr_ptr_q] <= pack_strb_acc;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef GLB_ST_DMA_CYCLE_COUNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (start_acc) begin
      cyc_q <= '0;
    end else if (busy_out && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end
  assign cycle_count_out = cyc_q;
`endif

  assign bus.strm_ready_out = strm_ready;
  assign bus.wr_en_out      = !fifo_empty;
  assign bus.wr_addr_out    = fifo_addr_q[rd_ptr_q];
  assign bus.wr_data_out    = fifo_data_q[rd_ptr_q];
  assign bus.wr_strb_out    = fifo_strb_q[rd_ptr_q];
  assign busy_out           = (state_q == StRun) || (state_q == StDrain);
  assign done_pulse_out     = (state_q == StDone);
  assign overflow_out       = overflow_q;

endmodule
